// File: rtl/pri_enc_pkg.sv
// Shared definitions for the priority-encoder / round-robin arbiter slice:
// arbitration mode encoding and the index-width helper.
package pri_enc_pkg;

    // Arbitration mode encoding, as driven on the mode input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Number of bits needed to hold an index in 0..n-1 (ceil(log2(n)), minimum 1).
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((32'sd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : pri_enc_pkg

// File: rtl/pri_enc_n.sv
// Combinational highest-set-bit search over an N-bit request vector.
// idx is the highest asserted position; any flags a non-zero vector.
// When req is all zero idx is 0, so it is always a legal index.
module pri_enc_n
    import pri_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] idx_s;

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        idx_s = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            idx_s = req[i] ? W'(i) : idx_s;
        end
    end

    assign idx = idx_s;
    assign any = |req;

endmodule : pri_enc_n

// File: rtl/pri_enc_rr_n.sv
// N-input arbiter with a registered, valid/ready handshaked grant index.
// mode=0 grants the highest requesting index; mode=1 grants round-robin,
// scanning downward from ptr with wrap. A single highest-set-bit encoder
// serves both modes: in round-robin mode the request vector is rotated so
// that position ptr lands at the top of the encoder's search space, and the
// encoder's answer is rotated back.
module pri_enc_rr_n
    import pri_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         mode,
    input  logic [N-1:0] req,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready
);

    // Registered state.
    logic [W-1:0] out_idx_r;
    logic         out_valid_r;
    logic [W-1:0] ptr_r;

    // Combinational datapath.
    logic [W:0]   shift_s;
    logic [N-1:0] rot_s;
    logic [N-1:0] enc_req_s;
    logic [W-1:0] enc_idx_s;
    logic         enc_any_s;
    logic [W:0]   sum_s;
    logic [W-1:0] grant_s;
    logic [W-1:0] ptr_next_s;
    logic         free_s;
    logic         capture_s;

    // Rotate req so that rot_s[j] = req[(ptr+1+j) mod N]; req[ptr] sits at
    // rot_s[N-1], req[ptr-1] just below it, and so on with wrap.
    always_comb begin
        shift_s = {1'b0, ptr_r} + {{W{1'b0}}, 1'b1};
        rot_s   = N'({req, req} >> shift_s);
    end

    // Feed the encoder the raw or the rotated vector depending on mode.
    always_comb begin
        if (mode == MODE_RR) begin
            enc_req_s = rot_s;
        end else begin
            enc_req_s = req;
        end
    end

    pri_enc_n #(
        .N (N)
    ) u_enc (
        .req (enc_req_s),
        .idx (enc_idx_s),
        .any (enc_any_s)
    );

    // Map the encoder's answer back to a channel index and derive the next ptr.
    always_comb begin
        sum_s = {1'b0, ptr_r} + {{W{1'b0}}, 1'b1} + {1'b0, enc_idx_s};
        if (mode == MODE_RR) begin
            if (sum_s >= (W+1)'(N)) begin
                grant_s = W'(sum_s - (W+1)'(N));
            end else begin
                grant_s = W'(sum_s);
            end
        end else begin
            grant_s = enc_idx_s;
        end
        if (grant_s == {W{1'b0}}) begin
            ptr_next_s = W'(N - 1);
        end else begin
            ptr_next_s = grant_s - {{(W-1){1'b0}}, 1'b1};
        end
    end

    // The output stage can take a new grant when empty or being drained now.
    always_comb begin
        free_s    = ~out_valid_r | out_ready;
        capture_s = free_s & en & enc_any_s;
    end

    // Grant register and round-robin pointer; reset dominates everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_idx_r   <= {W{1'b0}};
            ptr_r       <= W'(N - 1);
        end else if (capture_s) begin
            out_valid_r <= 1'b1;
            out_idx_r   <= grant_s;
            if (mode == MODE_RR) begin
                ptr_r <= ptr_next_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end else if (free_s) begin
            out_valid_r <= 1'b0;
            out_idx_r   <= out_idx_r;
            ptr_r       <= ptr_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_idx_r   <= out_idx_r;
            ptr_r       <= ptr_r;
        end
    end

    assign out_idx   = out_idx_r;
    assign out_valid = out_valid_r;

endmodule : pri_enc_rr_n

// File: tb/tb_pri_enc_rr_n.sv
// Self-checking bench for pri_enc_rr_n (N=8): directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// behavioural arbiter model.
module tb_pri_enc_rr_n;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         mode;
    logic [N-1:0] req;
    logic [W-1:0] out_idx;
    logic         out_valid;
    logic         out_ready;

    int errors = 0;
    int checks = 0;

    // Behavioural model state.
    int m_ptr;
    int m_idx;
    int m_valid;

    pri_enc_rr_n #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .req       (req),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Winner by the arbitration rules; -1 when nothing requests.
    function automatic int winner(input logic [N-1:0] r, input bit m, input int p);
        int w;
        int i;
        w = -1;
        if (!m) begin
            for (int k = N - 1; k >= 0; k--)
                if (r[k] && w < 0) w = k;
        end else begin
            for (int k = 0; k < N; k++) begin
                i = (p - k + N) % N;
                if (r[i] && w < 0) w = i;
            end
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: apply inputs, advance the model at the edge, compare after it.
    task automatic cyc(input bit r, input bit e, input bit m, input logic [N-1:0] q, input bit rdy);
        int g;
        rst = r; en = e; mode = m; req = q; out_ready = rdy;
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_idx = 0; m_ptr = N - 1;
        end else if (m_valid == 0 || rdy) begin
            g = winner(q, m, m_ptr);
            if (e && g >= 0) begin
                m_valid = 1;
                m_idx   = g;
                if (m) m_ptr = (g == 0) ? N - 1 : g - 1;
            end else begin
                m_valid = 0;
            end
        end
        #1;
        chk("model_valid", {31'd0, out_valid}, m_valid);
        chk("model_idx", {29'd0, out_idx}, m_idx);
    endtask

    initial begin
        int exp_seq [9];
        logic [N-1:0] rq;
        exp_seq = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        m_ptr = N - 1; m_idx = 0; m_valid = 0;

        // Reset with all requests asserted.
        cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b1);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_idx", {29'd0, out_idx}, 32'd0);

        // Fixed priority.
        cyc(1'b0, 1'b1, 1'b0, 8'b0010_0110, 1'b1);
        chk("fixed_idx5", {29'd0, out_idx}, 32'd5);
        chk("fixed_valid", {31'd0, out_valid}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 8'b0000_0001, 1'b1);
        chk("fixed_idx0", {29'd0, out_idx}, 32'd0);

        // Round-robin full sweep from reset.
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 9; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
            chk("rr_sweep", {29'd0, out_idx}, exp_seq[i]);
        end

        // Round-robin alternating between two requesters.
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 8'b0001_0010, 1'b1);
            chk("rr_alt", {29'd0, out_idx}, (i % 2 == 0) ? 32'd4 : 32'd1);
        end

        // Stall holds the grant while inputs change.
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 8'h08, 1'b1);
        chk("stall_setup", {29'd0, out_idx}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 8'h80, 1'b0);
            chk("stall_idx", {29'd0, out_idx}, 32'd3);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
        end
        cyc(1'b0, 1'b1, 1'b0, 8'h80, 1'b1);
        chk("stall_release", {29'd0, out_idx}, 32'd7);

        // Idle: en low, then req zero.
        cyc(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
        chk("idle_en_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_en_idx_hold", {29'd0, out_idx}, 32'd7);
        cyc(1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
        chk("idle_req_valid", {31'd0, out_valid}, 32'd0);

        // ptr holds across idle cycles and fixed-mode grants.
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
        chk("ptr_a", {29'd0, out_idx}, 32'd7);
        cyc(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
        chk("ptr_idle_hold", {29'd0, out_idx}, 32'd6);
        cyc(1'b0, 1'b1, 1'b0, 8'h01, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
        chk("ptr_fixed_hold", {29'd0, out_idx}, 32'd5);

        // Reset after RR grants restarts the rotation at the top.
        cyc(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
        chk("rst_rr_b", {29'd0, out_idx}, 32'd6);
        cyc(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
        chk("rst_rr_restart", {29'd0, out_idx}, 32'd7);

        // Reset in the middle of a stall discards the pending grant.
        cyc(1'b0, 1'b1, 1'b1, 8'h24, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 8'h24, 1'b0);
        chk("rst_stall_valid", {31'd0, out_valid}, 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 8'h24, 1'b1);
        chk("rst_stall_rr_eq_fixed", {29'd0, out_idx}, 32'd5);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rq = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rq = rq & 8'($urandom);
            if ($urandom_range(0, 15) == 0) rq = 8'h00;
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 7) != 0,
                1'($urandom),
                rq,
                $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pri_enc_rr_n

// File: doc/pri_enc_rr_n.md
PRI_ENC_RR_N -- requirements
Module: pri_enc_rr_n

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the number of request inputs; legal range 2..64.
REQ-002 The block SHALL have derived localparam W, default 3, meaning the index width, equal to $clog2(N).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port en  input  1  evaluation enable; when low, no new grant is captured.
REQ-006 The block SHALL have port mode  input  1  arbitration mode: 0 = fixed priority with the highest index winning, 1 = round-robin.
REQ-007 The block SHALL have port req  input  N  request vector, one bit per channel.
REQ-008 The block SHALL have port out_idx  output  W  index of the granted channel, registered.
REQ-009 The block SHALL have port out_valid  output  1  out_idx holds a grant not yet accepted.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts the grant when out_valid and out_ready are both high in the same cycle.

Function
REQ-011 The block SHALL capture a new grant when en=1, req!=0 and the output stage is free (out_valid=0, or out_valid=1 with out_ready=1).
REQ-012 Grant latency SHALL be one cycle: req sampled at edge k appears on out_idx/out_valid after edge k.
REQ-013 In fixed mode (mode=0) the winner SHALL be the highest set bit of req.
REQ-014 In round-robin mode (mode=1) the winner SHALL be the first set bit found scanning downward from index ptr, wrapping from 0 to N-1.
REQ-015 After a round-robin grant of index g, ptr SHALL become g-1, or N-1 when g=0.
REQ-016 Fixed-mode grants SHALL NOT modify ptr; a mode change SHALL take effect on the next capture with ptr unchanged.
REQ-017 While out_valid=1 and out_ready=0 (stall), out_idx, out_valid and ptr SHALL hold, and req/en/mode SHALL be ignored.
REQ-018 When the stage is free and (en=0 or req=0), out_valid SHALL be 0 after the edge; out_idx SHALL hold its last value, and ptr SHALL hold.
REQ-019 Back-to-back acceptance (out_ready=1 continuously, req nonzero, en=1) SHALL yield one grant per cycle with no bubble.
REQ-020 out_idx SHALL always be < N; no X or out-of-range value SHALL be produced for any req pattern.

Reset
REQ-021 While rst=1 at a clock edge: out_valid SHALL be 0, out_idx SHALL be 0, and ptr SHALL be N-1; rst SHALL override all other inputs.
REQ-022 Reset asserted mid-stall SHALL discard the pending grant; the first post-reset round-robin grant SHALL match the fixed-mode result.

Structure
REQ-023 A shared package pri_enc_pkg SHALL hold the mode encoding constants (MODE_FIXED=0, MODE_RR=1) and the function computing W from N.
REQ-024 The combinational highest-set-bit search SHALL be a sub-module pri_enc_n (parameter N; inputs req; outputs idx and any), instantiated once for fixed mode.
REQ-025 Round-robin SHALL be realised by rotating req by ptr into pri_enc_n's request space, or by a second pri_enc_n instance on a masked vector, and not by a case table.

Verification
REQ-026 Reset: rst=1 for 2 cycles with req=8'hFF -> out_valid=0, out_idx=0, ptr=7.
REQ-027 Fixed: N=8, mode=0, en=1, out_ready=1, req=8'b0010_0110 -> next cycle out_idx=5, out_valid=1; req=8'b0000_0001 -> out_idx=0.
REQ-028 Round-robin: mode=1, req=8'hFF held, out_ready=1 -> out_idx sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles; req=8'b0001_0010 -> alternating 4,1.
REQ-029 Stall: out_valid=1, out_idx=3, out_ready=0 for 3 cycles while req switches to 8'h80 -> out_idx stays 3; out_ready=1 -> next cycle out_idx=7.
REQ-030 Idle/drop: free stage with en=0 (or req=0) -> out_valid=0 next cycle, ptr unchanged; rst pulsed after RR grants 7,6 -> next RR grant on req=8'hFF is 7.
